// File: rtl/inst_fetch_unit.sv
// Instruction fetch sequencer: walks a PC through a synchronous-read
// instruction memory, loads each word into the instruction register and
// offers it to the execute stage over a valid/ready handshake. Jumps are
// taken on the accepting edge. Fetch stops after the halt opcode is consumed.
//
// Ports:
//   clk, sys_rst                 clock, synchronous active-low reset
//   start                        begin fetch at address 0 (IDLE/HALTED only)
//   imem_rd_en, imem_addr        instruction memory read strobe / address
//   imem_rdata                   read data, valid the cycle after imem_rd_en
//   ir_out, pc_out, ir_valid     instruction, its address, and valid flag
//   ir_ready                     execute stage accepts ir_out
//   jump_en, jump_addr           PC redirect, sampled on an accepting edge
//   halted                       halt instruction consumed
//   inst_count                   saturating count of accepted instructions
module inst_fetch_unit #(
   parameter int unsigned PROG_DEPTH = 16,
   parameter int unsigned AW         = 4,
   parameter logic [4:0]  HALT_OP    = 5'd27
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic          start,
   output logic          imem_rd_en,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_rdata,
   output logic [31:0]   ir_out,
   output logic [AW-1:0] pc_out,
   output logic          ir_valid,
   input  logic          ir_ready,
   input  logic          jump_en,
   input  logic [AW-1:0] jump_addr,
   output logic          halted,
   output logic [15:0]   inst_count
);

   localparam int unsigned CW = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD,
      S_HALTED
   } state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic [AW-1:0] next_pc_c;
   logic [CW-1:0] count_inc_c;
   logic          is_halt_c;

   // Successor address for an accepted non-halt instruction
   always_comb begin
      next_pc_c = pc + AW'(1);
      if (pc == AW'(PROG_DEPTH - 1)) begin
         next_pc_c = '0;
      end
      if (jump_en) begin
         next_pc_c = jump_addr;
      end
   end

   assign count_inc_c = (inst_count == {CW{1'b1}}) ? inst_count : inst_count + CW'(1);
   assign is_halt_c   = (ir_out[31:27] == HALT_OP);

   // Fetch FSM with registered outputs; the read strobe is raised on the
   // edge that enters FETCH so it is high exactly for the FETCH cycle.
   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         state      <= S_IDLE;
         pc         <= '0;
         ir_out     <= '0;
         pc_out     <= '0;
         ir_valid   <= 1'b0;
         halted     <= 1'b0;
         inst_count <= '0;
         imem_rd_en <= 1'b0;
         imem_addr  <= '0;
      end else begin
         imem_rd_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc         <= '0;
                  imem_addr  <= '0;
                  imem_rd_en <= 1'b1;
                  state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               ir_out   <= imem_rdata;
               pc_out   <= pc;
               ir_valid <= 1'b1;
               state    <= S_HOLD;
            end
            S_HOLD: begin
               if (ir_ready) begin
                  ir_valid   <= 1'b0;
                  inst_count <= count_inc_c;
                  if (is_halt_c) begin
                     halted <= 1'b1;
                     state  <= S_HALTED;
                  end else begin
                     pc         <= next_pc_c;
                     imem_addr  <= next_pc_c;
                     imem_rd_en <= 1'b1;
                     state      <= S_FETCH;
                  end
               end
            end
            S_HALTED: begin
               if (start) begin
                  pc         <= '0;
                  inst_count <= '0;
                  halted     <= 1'b0;
                  imem_addr  <= '0;
                  imem_rd_en <= 1'b1;
                  state      <= S_FETCH;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: synchronous-read memory model, scoreboard of
// expected (pc, word) pairs, directed sequence covering sequential fetch,
// backpressure, jumps, wrap-around, halt/restart and mid-operation reset.
module tb_inst_fetch_unit;

   localparam int unsigned AW = 4;
   localparam int unsigned DEPTH = 16;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [31:0]   word;
   } exp_t;

   logic          clk;
   logic          sys_rst;
   logic          start;
   logic          imem_rd_en;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic [31:0]   ir_out;
   logic [AW-1:0] pc_out;
   logic          ir_valid;
   logic          ir_ready;
   logic          jump_en;
   logic [AW-1:0] jump_addr;
   logic          halted;
   logic [15:0]   inst_count;

   logic [31:0] mem [DEPTH];
   exp_t        sb [$];
   int          n_cmp;
   int          n_err;
   int          exp_count;

   inst_fetch_unit #(.PROG_DEPTH(16), .AW(4), .HALT_OP(5'd27)) dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .start      (start),
      .imem_rd_en (imem_rd_en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .ir_out     (ir_out),
      .pc_out     (pc_out),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready),
      .jump_en    (jump_en),
      .jump_addr  (jump_addr),
      .halted     (halted),
      .inst_count (inst_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory, one cycle latency
   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= mem[imem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_chk(input string tag);
      check({tag, "_rd_en"},   32'(imem_rd_en), 32'd0);
      check({tag, "_addr"},    32'(imem_addr),  32'd0);
      check({tag, "_ir_out"},  ir_out,          32'd0);
      check({tag, "_pc_out"},  32'(pc_out),     32'd0);
      check({tag, "_valid"},   32'(ir_valid),   32'd0);
      check({tag, "_halted"},  32'(halted),     32'd0);
      check({tag, "_count"},   32'(inst_count), 32'd0);
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (ir_valid !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      if (ir_valid !== 1'b1) check({tag, "_valid_timeout"}, 32'(ir_valid), 32'd1);
   endtask

   task automatic present(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_ir_out"}, ir_out,      e.word);
         check({tag, "_pc_out"}, 32'(pc_out), 32'(e.pc));
      end
   endtask

   // Expect word at pc, optionally stall for hold cycles, then accept it
   task automatic step(input int pc, input bit j, input logic [AW-1:0] ja,
                       input int exp_lat, input int hold);
      string tag;
      int    lat;
      bit    is_halt;
      int    npc;
      tag = $sformatf("pc%0d", pc);
      sb.push_back({AW'(pc), mem[pc]});
      wait_valid(tag, lat);
      if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      present(tag);
      for (int k = 0; k < hold; k++) begin
         ir_ready = 1'b0;
         tick();
         check({tag, "_bp_valid"}, 32'(ir_valid),   32'd1);
         check({tag, "_bp_ir"},    ir_out,          mem[pc]);
         check({tag, "_bp_pc"},    32'(pc_out),     32'(pc));
         check({tag, "_bp_rd_en"}, 32'(imem_rd_en), 32'd0);
         check({tag, "_bp_count"}, 32'(inst_count), 32'(exp_count));
      end
      is_halt = (mem[pc][31:27] == 5'd27);
      npc = j ? int'(ja) : (pc + 1) % DEPTH;
      ir_ready  = 1'b1;
      jump_en   = j;
      jump_addr = ja;
      tick();
      ir_ready  = 1'b0;
      jump_en   = 1'b0;
      jump_addr = '0;
      exp_count++;
      check({tag, "_acc_count"}, 32'(inst_count), 32'(exp_count));
      check({tag, "_acc_valid"}, 32'(ir_valid),   32'd0);
      check({tag, "_acc_halted"}, 32'(halted),    32'(is_halt));
      check({tag, "_acc_rd_en"}, 32'(imem_rd_en), 32'(!is_halt));
      if (!is_halt) check({tag, "_acc_next_addr"}, 32'(imem_addr), 32'(npc));
   endtask

   initial begin
      int  lat;
      bit  seen;
      n_cmp     = 0;
      n_err     = 0;
      exp_count = 0;
      sys_rst   = 1'b0;
      start     = 1'b0;
      ir_ready  = 1'b0;
      jump_en   = 1'b0;
      jump_addr = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem[i] = 32'h2000_0000 | (32'(i) << 22) | 32'(i);
      end

      // Reset state
      tick();
      tick();
      reset_chk("reset");
      sys_rst = 1'b1;
      tick();
      check("idle_no_fetch", 32'(imem_rd_en), 32'd0);

      // Sequential fetch with start latency
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_rd_en", 32'(imem_rd_en), 32'd1);
      check("start_addr",  32'(imem_addr),  32'd0);
      step(0, 1'b0, '0, 2, 0);
      step(1, 1'b0, '0, 2, 0);
      step(2, 1'b0, '0, 2, 0);
      step(3, 1'b0, '0, 2, 0);
      // Backpressure, then jumps and wrap-around
      step(4, 1'b0, '0, 2, 5);
      step(5, 1'b0, '0, 2, 0);
      step(6, 1'b1, AW'(9), 2, 0);
      step(9, 1'b0, '0, 2, 0);
      step(10, 1'b1, AW'(14), 2, 0);
      step(14, 1'b0, '0, 2, 0);
      step(15, 1'b0, '0, 2, 0);
      step(0, 1'b0, '0, 2, 0);
      step(1, 1'b0, '0, 2, 0);

      // Halt: word 1 is the halt opcode, jump_en on its accept is ignored
      sys_rst = 1'b0;
      tick();
      sys_rst = 1'b1;
      exp_count = 0;
      reset_chk("reset2");
      mem[1] = {5'd27, 27'd0};
      start = 1'b1;
      tick();
      start = 1'b0;
      step(0, 1'b0, '0, 2, 0);
      step(1, 1'b1, AW'(5), 2, 0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (imem_rd_en !== 1'b0 || ir_valid !== 1'b0) seen = 1'b1;
      end
      check("halt_quiet", 32'(seen), 32'd0);
      check("halt_hold",  32'(halted), 32'd1);
      check("halt_count", 32'(inst_count), 32'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_count = 0;
      check("restart_halted", 32'(halted),     32'd0);
      check("restart_count",  32'(inst_count), 32'd0);
      check("restart_rd_en",  32'(imem_rd_en), 32'd1);
      check("restart_addr",   32'(imem_addr),  32'd0);
      step(0, 1'b0, '0, 2, 0);

      // Reset during WAIT (accept edge -> FETCH, one more edge -> WAIT)
      tick();
      sys_rst = 1'b0;
      tick();
      sys_rst = 1'b1;
      reset_chk("rst_wait");
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (imem_rd_en !== 1'b0 || ir_valid !== 1'b0) seen = 1'b1;
      end
      check("rst_wait_idle", 32'(seen), 32'd0);

      // Reset during HOLD with a valid instruction pending
      start = 1'b1;
      tick();
      start = 1'b0;
      sb.push_back({AW'(0), mem[0]});
      wait_valid("rst_hold", lat);
      check("rst_hold_latency", 32'(lat), 32'd2);
      present("rst_hold");
      sys_rst = 1'b0;
      tick();
      sys_rst = 1'b1;
      reset_chk("rst_hold");
      tick();
      tick();
      check("rst_hold_idle", 32'(imem_rd_en), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch sequencer feeding the processor's execute stage. It steps a program counter through a synchronous-read instruction memory and loads each 32-bit word into the instruction register. It presents the word to the execute stage over a valid/ready handshake and redirects the PC on jumps resolved by the execute stage. It stops on the halt opcode.

## Interface
- `PROG_DEPTH`, 16 — instruction memory depth in words; power of two.
- `AW`, 4 — address width; equals log2(`PROG_DEPTH`).
- `HALT_OP`, 5'd27 — `oper_type` value (IR[31:27]) that halts fetch.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `sys_rst`  in  1  — synchronous, active-low reset.
- `start`  in  1  — begin fetch from address 0; honoured in IDLE and HALTED only.
- `imem_rd_en`  out  1  — instruction memory read strobe.
- `imem_addr`  out  AW  — read address.
- `imem_rdata`  in  32  — read data, valid the cycle after `imem_rd_en`.
- `ir_out`  out  32  — instruction register to execute stage.
- `pc_out`  out  AW  — address of the word in `ir_out`.
- `ir_valid`  out  1  — `ir_out` holds an unconsumed instruction.
- `ir_ready`  in  1  — execute stage accepts `ir_out`.
- `jump_en`  in  1  — redirect PC; sampled only on an accepting edge.
- `jump_addr`  in  AW  — jump target.
- `halted`  out  1  — halt instruction consumed; fetch stopped.
- `inst_count`  out  16  — instructions accepted since start; saturates at 16'hFFFF.

## Operation
- Reset (`sys_rst`=0 at an edge) clears the following; it overrides every other input, including mid-fetch, mid-hold or HALTED:
  - state to IDLE
  - `pc` = 0, `ir_out` = 0, `pc_out` = 0
  - `ir_valid` = 0, `halted` = 0, `inst_count` = 0
  - `imem_rd_en` = 0, `imem_addr` = 0
- FSM:
  - IDLE: `start`=1 → FETCH with `pc`=0.
  - FETCH: `imem_rd_en`=1, `imem_addr`=`pc`; → WAIT.
  - WAIT: `ir_out`←`imem_rdata`, `pc_out`←`pc`, `ir_valid`←1; → HOLD.
  - HOLD: `ir_out`/`pc_out` stable while `ir_valid`=1 and `ir_ready`=0. On accept (`ir_valid`&`ir_ready`):
    - `ir_valid`←0 and `inst_count`+1 (saturating).
    - If `ir_out[31:27]`==`HALT_OP`: `halted`←1, → HALTED; `jump_en` is ignored.
    - Else if `jump_en`: `pc`←`jump_addr`, → FETCH.
    - Else: `pc`←`pc`+1, wrapping `PROG_DEPTH`-1 → 0; → FETCH.
  - HALTED: `start`=1 → FETCH, with `pc`=0, `inst_count`=0 and `halted`=0. Otherwise hold.
- `imem_rd_en` is high only in FETCH. `imem_addr` holds its last value otherwise.
- `jump_en` and `ir_ready` are ignored outside HOLD. `start` is ignored in FETCH, WAIT and HOLD.
- The halt instruction is itself presented and counted. The execute stage sees it before fetch stops.

## Timing
- Memory read latency is exactly 1 cycle. Read data is captured on the WAIT→HOLD edge.
- Start sampled at edge s gives `ir_valid`=1 after edge s+2.
- Accept at edge t gives the next `ir_valid`=1 after edge t+2. Two bubble cycles; peak throughput is 1 instruction per 3 cycles.
- The PC redirect takes effect for the fetch immediately after the accepting edge. No wrong-path word is ever presented.
- `halted` rises on the same edge that consumes the halt instruction.
- `inst_count` updates on the accepting edge.

## Test plan
- Reset then sequential fetch:
  - Setup: mem[0..3] = 32'h2000_0000, 32'h2040_0001, 32'h2080_0002, 32'h20C0_0003; `ir_ready` tied 1; `start` pulse.
  - Expect: `ir_out` shows each word in order with `pc_out` 0..3; `ir_valid` high 1 of every 3 cycles; `inst_count`=4 after the 4th accept.
- Backpressure:
  - Setup: hold `ir_ready`=0 for 5 cycles in HOLD.
  - Expect: `ir_out`, `pc_out` and `ir_valid` stay stable, no `imem_rd_en`, `inst_count` unchanged; the instruction is accepted the cycle `ir_ready` rises.
- Jump:
  - Setup: accept the word at `pc_out`=2 with `jump_en`=1, `jump_addr`=9.
  - Expect: next `imem_addr`=9 and next `pc_out`=9; word 3 is never presented.
- Halt:
  - Setup: mem[1] = {5'd27, 27'd0}.
  - Expect: word 1 is presented; on its accept `halted`=1, `inst_count`=2, and `imem_rd_en` stays 0 for 20 cycles. A `start` then refetches address 0 with `inst_count`=0.
- Wrap-around:
  - Setup: `PROG_DEPTH`=16, no halt or jump.
  - Expect: after `pc_out`=15 the next `pc_out`=0.
- Reset mid-operation:
  - Setup: assert `sys_rst`=0 for 1 cycle during WAIT, then again during HOLD with `ir_valid`=1.
  - Expect: all outputs return to their reset values the next edge and state is IDLE; nothing is fetched until `start`.
